// File: rtl/divider_share_arbiter.sv
// Two-requester front end for a shared combinational 16/8 array divider.
// Round-robin grant, registered operands to the array, fixed settle wait,
// then a held result with valid/ready and divide-by-zero / overflow flags.
module divider_share_arbiter #(
  parameter int NW         = 16,
  parameter int DW         = 8,
  parameter int SETTLE_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [NW-1:0] req_n0,
  input  logic [DW-1:0] req_d0,
  input  logic [NW-1:0] req_n1,
  input  logic [DW-1:0] req_d1,
  output logic [NW-1:0] div_n,
  output logic [DW-1:0] div_d,
  input  logic [DW-1:0] div_q,
  input  logic [DW-1:0] div_r,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_q,
  output logic [DW-1:0] rsp_r,
  output logic          rsp_dz,
  output logic          rsp_ovf,
  output logic [15:0]   op_cnt
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            rr_last;
  logic            gnt_id;
  logic            acc;
  logic [NW-1:0]   n_sel;
  logic [DW-1:0]   d_sel;

  // Grant and operand select: requester 0 unless only 1 is valid or 1 is owed the turn
  always_comb begin
    req_ready = 2'b00;
    gnt_id    = 1'b0;
    acc       = 1'b0;
    if (state == IDLE && !rst) begin
      case (req_valid)
        2'b01:   begin gnt_id = 1'b0;     acc = 1'b1; end
        2'b10:   begin gnt_id = 1'b1;     acc = 1'b1; end
        2'b11:   begin gnt_id = ~rr_last; acc = 1'b1; end
        default: begin gnt_id = 1'b0;     acc = 1'b0; end
      endcase
      if (acc) req_ready[gnt_id] = 1'b1;
    end
    n_sel = gnt_id ? req_n1 : req_n0;
    d_sel = gnt_id ? req_d1 : req_d0;
  end

  // Next state: zero divisor skips the settle wait since the array output is unused
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = (d_sel == '0) ? HOLD : SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == HOLD);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, settle counter, result capture and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_n   <= '0;
      div_d   <= '0;
      rsp_id  <= 1'b0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_dz  <= 1'b0;
      rsp_ovf <= 1'b0;
      rr_last <= 1'b1;
      cnt     <= '0;
      op_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          div_n   <= n_sel;
          div_d   <= d_sel;
          rsp_id  <= gnt_id;
          rr_last <= gnt_id;
          cnt     <= CW'(SETTLE_CYC - 1);
          if (d_sel == '0) begin
            rsp_q   <= '1;
            rsp_r   <= n_sel[DW-1:0];
            rsp_dz  <= 1'b1;
            rsp_ovf <= 1'b0;
          end else begin
            rsp_dz  <= 1'b0;
            rsp_ovf <= (n_sel[NW-1:DW] >= d_sel);
          end
        end
        SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            rsp_q <= div_q;
            rsp_r <= div_r;
          end
        end
        HOLD: if (rsp_ready) op_cnt <= op_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_share_arbiter.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on handshake.
module tb_divider_share_arbiter;

  localparam int NW = 16, DW = 8, SC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [NW-1:0] req_n0 = '0, req_n1 = '0;
  logic [DW-1:0] req_d0 = '0, req_d1 = '0;
  logic [NW-1:0] div_n;
  logic [DW-1:0] div_d;
  logic [DW-1:0] div_q, div_r;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [DW-1:0] rsp_q, rsp_r;
  logic          rsp_dz, rsp_ovf;
  logic [15:0]   op_cnt;

  always #5 clk = ~clk;

  divider_share_arbiter #(.NW(NW), .DW(DW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_n0(req_n0), .req_d0(req_d0), .req_n1(req_n1), .req_d1(req_d1),
    .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf),
    .op_cnt(op_cnt)
  );

  // Exact array model: quotient truncated to DW bits
  logic [NW-1:0] qfull;
  always_comb begin
    qfull = '1;
    div_r = '0;
    if (div_d != '0) begin
      qfull = div_n / {{(NW-DW){1'b0}}, div_d};
      div_r = DW'(div_n % {{(NW-DW){1'b0}}, div_d});
    end
    div_q = qfull[DW-1:0];
  end

  typedef struct {
    logic          id;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ovf;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [DW-1:0] q, input logic [DW-1:0] r,
                              input logic dz, input logic ovf, input int lat);
    exp_t e;
    e.id = id; e.q = q; e.r = r; e.dz = dz; e.ovf = ovf; e.lat = lat;
    return e;
  endfunction

  // Monitor: latency from accept cycle to first valid cycle, field compare on handshake
  int  lat = 0;
  bit  trk = 0;
  always @(negedge clk) begin
    if (rst) trk = 0;
    else begin
      if (|(req_valid & req_ready)) begin trk = 1; lat = 0; end
      else if (trk) lat++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          if (trk) begin chk("latency", lat, exp_q[0].lat); trk = 0; end
          if (rsp_ready) begin
            chk("rsp_id",  32'(rsp_id),  32'(exp_q[0].id));
            chk("rsp_q",   32'(rsp_q),   32'(exp_q[0].q));
            chk("rsp_r",   32'(rsp_r),   32'(exp_q[0].r));
            chk("rsp_dz",  32'(rsp_dz),  32'(exp_q[0].dz));
            chk("rsp_ovf", 32'(rsp_ovf), 32'(exp_q[0].ovf));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_ready(input int i);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    if (k == 50) chk("grant_timeout", 32'(req_ready[i]), 32'd1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (k == 100) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Single request from requester i, valid dropped right after the accept edge
  task automatic do_req(input int i, input logic [NW-1:0] n, input logic [DW-1:0] d);
    @(posedge clk); #1;
    if (i == 0) begin req_n0 = n; req_d0 = d; end
    else        begin req_n1 = n; req_d1 = d; end
    req_valid[i] = 1'b1;
    wait_ready(i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_op_cnt", 32'(op_cnt), 0);
    chk("rst_div_n", 32'(div_n), 0);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = 2'b00;
    @(posedge clk); #1 rst = 1'b0;

    // 200/7 = 28 r 4
    exp_q.push_back(mk(1'b0, 8'd28, 8'd4, 1'b0, 1'b0, SC + 1));
    do_req(0, 16'd200, 8'd7);
    drain();

    // divide by zero: q=FF r=low byte of n, skips settle
    exp_q.push_back(mk(1'b1, 8'hFF, 8'h34, 1'b1, 1'b0, 1));
    do_req(1, 16'h1234, 8'h00);
    drain();

    // overflow: 0x900/8 = 0x120, array gives low byte 0x20 r 0
    exp_q.push_back(mk(1'b0, 8'h20, 8'h00, 1'b0, 1'b1, SC + 1));
    do_req(0, 16'h0900, 8'h08);
    drain();
    chk("op_cnt_3", 32'(op_cnt), 3);

    // backpressure: 1000/10 = 100 r 0 held for 10 cycles
    rsp_ready = 1'b0;
    exp_q.push_back(mk(1'b1, 8'd100, 8'd0, 1'b0, 1'b0, SC + 1));
    do_req(1, 16'd1000, 8'd10);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (rsp_valid) break;
      end
      if (k == 50) chk("bp_timeout", 32'(rsp_valid), 1);
    end
    @(posedge clk); #1;
    req_n0 = 16'd77; req_d0 = 8'd7; req_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_q", 32'(rsp_q), 100);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_opcnt", 32'(op_cnt), 3);
      chk("bp_div_d", 32'(div_d), 10);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", 32'(req_ready), 32'b01);
    chk("bp_idle_valid", 32'(rsp_valid), 0);
    chk("bp_opcnt_4", 32'(op_cnt), 4);
    #1 req_valid = 2'b00;
    repeat (2) @(negedge clk);

    // reset while in SETTLE drops the operation
    do_req(0, 16'd50, 8'd5);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst2_valid", 32'(rsp_valid), 0);
    chk("rst2_opcnt", 32'(op_cnt), 0);
    chk("rst2_div_n", 32'(div_n), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);

    // both valid continuously: 100/3 = 33 r 1, 500/9 = 55 r 5; grants 0,1,0,1
    @(posedge clk); #1;
    req_n0 = 16'd100; req_d0 = 8'd3;
    req_n1 = 16'd500; req_d1 = 8'd9;
    for (int k = 0; k < 4; k++)
      exp_q.push_back((k % 2) ? mk(1'b1, 8'd55, 8'd5, 1'b0, 1'b0, SC + 1)
                              : mk(1'b0, 8'd33, 8'd1, 1'b0, 1'b0, SC + 1));
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int w;
      for (w = 0; w < 50; w++) begin
        @(negedge clk);
        if (req_ready != 2'b00) break;
      end
      if (w == 50) chk("rr_timeout", 32'(req_ready), 1);
      chk("rr_grant", 32'(req_ready), (k % 2) ? 32'b10 : 32'b01);
      @(posedge clk);
    end
    #1 req_valid = 2'b00;
    drain();
    chk("rr_opcnt_4", 32'(op_cnt), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
